// File: rtl/axi_copy_master.sv
// AXI4 memory-to-memory copy engine: one INCR read burst streamed through a small FIFO
// into one INCR write burst of the same length, with a sticky error flag.
module axi_copy_master #(
  parameter int AXI_AWIDTH   = 64,
  parameter int AXI_DWIDTH   = 64,
  parameter int BUF_LOGDEPTH = 3
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [AXI_AWIDTH-1:0]   cmd_src,
  input  logic [AXI_AWIDTH-1:0]   cmd_dst,
  input  logic [7:0]              cmd_len,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  output logic                    done,
  output logic                    err,
  output logic [3:0]              m_arid,
  output logic [AXI_AWIDTH-1:0]   m_araddr,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  output logic [7:0]              m_arlen,
  output logic [2:0]              m_arsize,
  output logic [1:0]              m_arburst,
  input  logic [3:0]              m_rid,
  input  logic [AXI_DWIDTH-1:0]   m_rdata,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  input  logic                    m_rlast,
  input  logic [1:0]              m_rresp,
  output logic [3:0]              m_awid,
  output logic [AXI_AWIDTH-1:0]   m_awaddr,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [7:0]              m_awlen,
  output logic [2:0]              m_awsize,
  output logic [1:0]              m_awburst,
  output logic [3:0]              m_wid,
  output logic [AXI_DWIDTH-1:0]   m_wdata,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  output logic                    m_wlast,
  output logic [AXI_DWIDTH/8-1:0] m_wstrb,
  input  logic [3:0]              m_bid,
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready
);

  localparam int BYTES = AXI_DWIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);
  localparam int DEPTH = 1 << BUF_LOGDEPTH;
  localparam logic [AXI_AWIDTH-1:0]   ADDR_MASK = AXI_AWIDTH'(BYTES - 1);
  localparam logic [BUF_LOGDEPTH:0]   FULL_OCC  = (BUF_LOGDEPTH + 1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, DONE} state_e;
  state_e state_q, state_d;

  logic [AXI_AWIDTH-1:0]   src_q, dst_q;
  logic [7:0]              len_q;
  logic                    ar_done_q, aw_done_q;
  logic [8:0]              rcnt_q, wcnt_q;
  logic                    err_q;
  logic [AXI_DWIDTH-1:0]   buf_q [DEPTH];
  logic [BUF_LOGDEPTH:0]   wptr_q, rptr_q;

  logic                    accept, ar_fire, aw_fire, r_fire, w_fire, b_fire;
  logic                    buf_full, buf_empty, rd_cmp, wr_cmp, err_set;
  logic [8:0]              len_ext;
  logic [BUF_LOGDEPTH:0]   occ;
  logic                    unused_ids;

  assign unused_ids = ^{m_rid, m_bid};

  assign len_ext   = {1'b0, len_q};
  assign occ       = wptr_q - rptr_q;
  assign buf_empty = (wptr_q == rptr_q);
  assign buf_full  = (occ == FULL_OCC);
  assign rd_cmp    = (rcnt_q == len_ext + 9'd1);
  assign wr_cmp    = (wcnt_q == len_ext + 9'd1);

  assign cmd_ready = (state_q == IDLE);
  assign done      = (state_q == DONE);
  assign err       = err_q;

  assign m_arid    = 4'd0;
  assign m_araddr  = src_q & ~ADDR_MASK;
  assign m_arvalid = (state_q == ADDR) && !ar_done_q;
  assign m_arlen   = len_q;
  assign m_arsize  = 3'(SIZE);
  assign m_arburst = 2'b01;

  assign m_awid    = 4'd0;
  assign m_awaddr  = dst_q & ~ADDR_MASK;
  assign m_awvalid = (state_q == ADDR) && !aw_done_q;
  assign m_awlen   = len_q;
  assign m_awsize  = 3'(SIZE);
  assign m_awburst = 2'b01;

  assign m_rready  = (state_q == DATA) && !buf_full;
  assign m_wid     = 4'd0;
  assign m_wvalid  = (state_q == DATA) && !buf_empty && !wr_cmp;
  assign m_wdata   = buf_q[rptr_q[BUF_LOGDEPTH-1:0]];
  assign m_wlast   = (state_q == DATA) && (wcnt_q == len_ext);
  assign m_wstrb   = '1;
  assign m_bready  = (state_q == RESP);

  assign accept  = cmd_valid && cmd_ready;
  assign ar_fire = m_arvalid && m_arready;
  assign aw_fire = m_awvalid && m_awready;
  assign r_fire  = m_rvalid && m_rready;
  assign w_fire  = m_wvalid && m_wready;
  assign b_fire  = m_bvalid && m_bready;

  // rlast must coincide with the beat that completes the burst
  assign err_set = (r_fire && ((m_rresp != 2'b00) || (m_rlast != (rcnt_q == len_ext))))
                || (b_fire && (m_bresp != 2'b00));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ADDR;
      ADDR:    if (ar_done_q && aw_done_q) state_d = DATA;
      DATA:    if (rd_cmp && wr_cmp) state_d = RESP;
      RESP:    if (b_fire) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      ar_done_q <= 1'b0;
      aw_done_q <= 1'b0;
      rcnt_q    <= '0;
      wcnt_q    <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        src_q <= cmd_src;
        dst_q <= cmd_dst;
        len_q <= cmd_len;
      end
      if (ar_fire) ar_done_q <= 1'b1;
      if (aw_fire) aw_done_q <= 1'b1;
      if (r_fire) begin
        rcnt_q <= rcnt_q + 9'd1;
        wptr_q <= wptr_q + 1'b1;
      end
      if (w_fire) begin
        wcnt_q <= wcnt_q + 9'd1;
        rptr_q <= rptr_q + 1'b1;
      end
      if (state_q == DONE) begin
        ar_done_q <= 1'b0;
        aw_done_q <= 1'b0;
        rcnt_q    <= '0;
        wcnt_q    <= '0;
      end
      if (accept)       err_q <= 1'b0;
      else if (err_set) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (r_fire) buf_q[wptr_q[BUF_LOGDEPTH-1:0]] <= m_rdata;
  end

endmodule

// File: tb/tb_axi_copy_master.sv
// Directed bench for axi_copy_master: a reactive AXI slave feeds read data into a scoreboard
// that the write beats are checked against, alongside address, wlast, occupancy and err checks.
module tb_axi_copy_master;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [63:0] cmd_src, cmd_dst;
  logic [7:0]  cmd_len;
  logic        cmd_valid, cmd_ready, done, err;
  logic [3:0]  m_arid, m_rid, m_awid, m_wid, m_bid;
  logic [63:0] m_araddr, m_awaddr, m_rdata, m_wdata;
  logic        m_arvalid, m_arready, m_awvalid, m_awready;
  logic [7:0]  m_arlen, m_awlen, m_wstrb;
  logic [2:0]  m_arsize, m_awsize;
  logic [1:0]  m_arburst, m_awburst, m_rresp, m_bresp;
  logic        m_rvalid, m_rready, m_rlast, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;

  axi_copy_master dut (
    .clk(clk), .resetn(resetn),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .done(done), .err(err),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_rlast(m_rlast), .m_rresp(m_rresp),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_wid(m_wid), .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_wlast(m_wlast), .m_wstrb(m_wstrb),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] addr; logic [7:0] len; } addrExp_t;
  addrExp_t    expAr[$];
  addrExp_t    expAw[$];
  logic [63:0] expW[$];
  addrExp_t    arE, awE;

  int errors = 0;
  int checks = 0;
  int rFires, wFires, occ, occBefore, maxOcc, cyc, lastB;
  int rBeat, rLen, wBeat, wLen, wHold, wHoldCfg;
  bit rActive, bPend, stallOn;
  bit arF, awF, rF, wF, bF;
  logic [1:0] bRespVal;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave: sample handshakes at negedge (they fire at the next posedge), drive at posedge+1
  always begin
    @(negedge clk);
    cyc++;
    {arF, awF, rF, wF, bF} = '0;
    if (!resetn) begin
      expW.delete();
      occ = 0; rActive = 0; bPend = 0; wBeat = 0; rBeat = 0; wHold = 0;
    end else begin
      arF = m_arvalid && m_arready;
      awF = m_awvalid && m_awready;
      rF  = m_rvalid && m_rready;
      wF  = m_wvalid && m_wready;
      bF  = m_bvalid && m_bready;
      occBefore = occ;
      if (done) checkOutput("doneAfterB", 64'(cyc - lastB), 64'd1);
      if (occBefore == DEPTH) checkOutput("rreadyFull", 64'(m_rready), 64'd0);
      if (arF) begin
        if (expAr.size() == 0) checkOutput("arUnexpected", 64'd1, 64'd0);
        else begin
          arE = expAr.pop_front();
          checkOutput("araddr", m_araddr, arE.addr);
          checkOutput("arlen", 64'(m_arlen), 64'(arE.len));
          checkOutput("arsizeBurst", 64'({m_arsize, m_arburst}), 64'({3'd3, 2'b01}));
          rActive = 1; rBeat = 0; rLen = int'(arE.len);
        end
      end
      if (awF) begin
        if (expAw.size() == 0) checkOutput("awUnexpected", 64'd1, 64'd0);
        else begin
          awE = expAw.pop_front();
          checkOutput("awaddr", m_awaddr, awE.addr);
          checkOutput("awlen", 64'(m_awlen), 64'(awE.len));
          checkOutput("awsizeBurst", 64'({m_awsize, m_awburst}), 64'({3'd3, 2'b01}));
          wBeat = 0; wLen = int'(awE.len); wHold = wHoldCfg;
        end
      end
      if (rF) begin
        expW.push_back(m_rdata);
        rFires++; occ++;
        rBeat++;
        if (rBeat > rLen) rActive = 0;
      end
      if (wF) begin
        if (expW.size() == 0) checkOutput("wNoData", 64'd1, 64'd0);
        else checkOutput("wdata", m_wdata, expW.pop_front());
        checkOutput("wlast", 64'(m_wlast), 64'(wBeat == wLen));
        checkOutput("wstrb", 64'(m_wstrb), 64'hFF);
        if (wBeat == wLen) bPend = 1;
        wBeat++; wFires++; occ--;
      end
      if (occ > maxOcc) maxOcc = occ;
      if (bF) begin
        bPend = 0;
        lastB = cyc;
      end
    end
    @(posedge clk);
    #1;
    if (!resetn) begin
      {m_arready, m_awready, m_rvalid, m_rlast, m_wready, m_bvalid} = '0;
    end else begin
      m_arready = stallOn ? ($urandom_range(0, 1) == 1) : 1'b1;
      m_awready = stallOn ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (!m_rvalid || rF) begin
        if (rActive && (!stallOn || $urandom_range(0, 3) != 0)) begin
          m_rvalid = 1'b1;
          m_rdata  = {$urandom, $urandom};
          m_rid    = 4'($urandom);
          m_rlast  = (rBeat == rLen);
        end else begin
          m_rvalid = 1'b0;
          m_rlast  = 1'b0;
        end
      end
      if (wHold > 0) begin
        m_wready = 1'b0;
        wHold--;
      end else m_wready = stallOn ? ($urandom_range(0, 3) != 0) : 1'b1;
      m_bvalid = bPend;
      m_bresp  = bRespVal;
      m_bid    = 4'($urandom);
    end
  end

  task automatic applyStimulus(input logic [63:0] src, input logic [63:0] dst, input logic [7:0] len);
    addrExp_t e;
    bit accepted = 0;
    e.addr = src & ~64'h7; e.len = len; expAr.push_back(e);
    e.addr = dst & ~64'h7; expAw.push_back(e);
    @(posedge clk); #2;
    cmd_src = src; cmd_dst = dst; cmd_len = len; cmd_valid = 1'b1;
    for (int i = 0; i < 100 && !accepted; i++) begin
      @(negedge clk);
      if (cmd_ready) accepted = 1;
      @(posedge clk); #2;
    end
    cmd_valid = 1'b0;
    checkOutput("cmdAccepted", 64'(accepted), 64'd1);
  endtask

  task automatic waitDone(input string tag, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    checkOutput(tag, 64'(seen), 64'd1);
    if (seen) begin
      @(negedge clk);
      checkOutput({tag, "Pulse"}, 64'(done), 64'd0);
    end
  endtask

  task automatic resetCounts();
    rFires = 0; wFires = 0; maxOcc = 0;
  endtask

  initial begin
    bit reached;
    cmd_src = '0; cmd_dst = '0; cmd_len = '0; cmd_valid = 1'b0;
    m_arready = 0; m_awready = 0; m_rvalid = 0; m_rlast = 0; m_rdata = '0; m_rid = '0;
    m_rresp = 2'b00; m_wready = 0; m_bvalid = 0; m_bresp = 2'b00; m_bid = '0;
    stallOn = 0; bRespVal = 2'b00; wHoldCfg = 0; lastB = -10; cyc = 0; occ = 0;
    resetCounts();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstCmdReady", 64'(cmd_ready), 64'd1);
    checkOutput("rstOutputs", 64'({done, err, m_arvalid, m_awvalid, m_rready, m_wvalid, m_wlast, m_bready}), 64'd0);
    @(posedge clk); #2;
    resetn = 1'b1;

    $display("[TB] single beat");
    resetCounts();
    applyStimulus(64'h100, 64'h200, 8'd0);
    waitDone("t1Done", 200);
    checkOutput("t1Reads", 64'(rFires), 64'd1);
    checkOutput("t1Writes", 64'(wFires), 64'd1);
    checkOutput("t1Err", 64'(err), 64'd0);

    $display("[TB] write backpressure");
    resetCounts();
    wHoldCfg = 12;
    applyStimulus(64'h800, 64'h900, 8'd15);
    waitDone("t2Done", 400);
    wHoldCfg = 0;
    checkOutput("t2Reads", 64'(rFires), 64'd16);
    checkOutput("t2Writes", 64'(wFires), 64'd16);
    checkOutput("t2MaxOcc", 64'(maxOcc), 64'(DEPTH));

    $display("[TB] max burst with random stalls");
    resetCounts();
    stallOn = 1;
    applyStimulus(64'h10000, 64'h20000, 8'd255);
    waitDone("t3Done", 6000);
    stallOn = 0;
    checkOutput("t3Reads", 64'(rFires), 64'd256);
    checkOutput("t3Writes", 64'(wFires), 64'd256);
    checkOutput("t3Err", 64'(err), 64'd0);

    $display("[TB] write response error");
    bRespVal = 2'b10;
    applyStimulus(64'h300, 64'h400, 8'd2);
    waitDone("t4Done", 200);
    checkOutput("t4ErrSet", 64'(err), 64'd1);
    repeat (3) @(negedge clk);
    checkOutput("t4ErrSticky", 64'(err), 64'd1);
    bRespVal = 2'b00;
    applyStimulus(64'h500, 64'h600, 8'd1);
    @(negedge clk);
    checkOutput("t4ErrCleared", 64'(err), 64'd0);
    waitDone("t4bDone", 200);
    checkOutput("t4bErr", 64'(err), 64'd0);

    $display("[TB] misaligned addresses");
    resetCounts();
    applyStimulus(64'h107, 64'h20F, 8'd1);
    waitDone("t5Done", 200);
    checkOutput("t5Writes", 64'(wFires), 64'd2);

    $display("[TB] reset mid transfer");
    resetCounts();
    applyStimulus(64'h1000, 64'h2000, 8'd15);
    reached = 0;
    for (int i = 0; i < 500 && !reached; i++) begin
      @(posedge clk); #2;
      if (wFires >= 5) reached = 1;
    end
    checkOutput("t6Reached5", 64'(reached), 64'd1);
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("t6RstCmdReady", 64'(cmd_ready), 64'd1);
    checkOutput("t6RstOutputs", 64'({m_arvalid, m_awvalid, m_rready, m_wvalid, m_bready, done, err}), 64'd0);
    @(posedge clk); #2;
    resetn = 1'b1;
    resetCounts();
    applyStimulus(64'h3000, 64'h4000, 8'd3);
    waitDone("t6Done", 200);
    checkOutput("t6Reads", 64'(rFires), 64'd4);
    checkOutput("t6Writes", 64'(wFires), 64'd4);
    checkOutput("t6Err", 64'(err), 64'd0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_copy_master.md
AXI_COPY_MASTER -- requirements
Module: axi_copy_master

Interface
REQ-001 SHALL have parameter AXI_AWIDTH, default 64: AXI address width.
REQ-002 SHALL have parameter AXI_DWIDTH, default 64: AXI data width; bytes per beat = AXI_DWIDTH/8.
REQ-003 SHALL have parameter BUF_LOGDEPTH, default 3: log2 of read-data buffer depth.
REQ-004 SHALL have ports:
- clk  in  1: sole clock.
- resetn  in  1: reset, synchronous, active-low.
- cmd_src  in  AXI_AWIDTH: source byte address.
- cmd_dst  in  AXI_AWIDTH: destination byte address.
- cmd_len  in  8: beats minus one.
- cmd_valid  in  1 / cmd_ready  out  1: command handshake.
- done  out  1: one-cycle completion pulse.
- err  out  1: sticky error flag.
- m_arid/araddr/arvalid/arready/arlen/arsize/arburst: AXI read address; widths 4, AXI_AWIDTH, 1, 1, 8, 3, 2.
- m_rid/rdata/rvalid/rready/rlast/rresp: AXI read data; widths 4, AXI_DWIDTH, 1, 1, 1, 2.
- m_awid/awaddr/awvalid/awready/awlen/awsize/awburst: AXI write address; widths as the AR channel.
- m_wid/wdata/wvalid/wready/wlast/wstrb: AXI write data; widths 4, AXI_DWIDTH, 1, 1, 1, AXI_DWIDTH/8.
- m_bid/bresp/bvalid/bready: AXI write response; widths 4, 2, 1, 1.

Function
REQ-005 SHALL implement states IDLE, ADDR, DATA, RESP, DONE.
REQ-006 SHALL assert cmd_ready only in IDLE and accept a command on cmd_valid & cmd_ready, moving IDLE->ADDR.
REQ-007 SHALL latch src, dst and len on command accept and hold them until DONE.
REQ-008 SHALL force the low log2(AXI_DWIDTH/8) bits of araddr and awaddr to zero.
REQ-009 SHALL drive arid, awid and wid to 0, arlen and awlen to the latched len, arsize and awsize to log2(AXI_DWIDTH/8), and arburst and awburst to INCR (2'b01).
REQ-010 SHALL assert arvalid and awvalid in ADDR, each held until its own fire; a per-channel done flag records each fire.
REQ-011 SHALL move ADDR->DATA in the cycle after both AR and AW have fired, in either order or simultaneously.
REQ-012 SHALL implement the read buffer as a FIFO of 2^BUF_LOGDEPTH entries, AXI_DWIDTH wide, with rready = DATA & buffer not full.
REQ-013 SHALL enqueue rdata on each R fire and count R beats; the count reaching len+1 marks read complete.
REQ-014 SHALL set wvalid = DATA & buffer not empty & W not complete, with wdata = buffer head and wstrb all ones.
REQ-015 SHALL dequeue the buffer and increment the W beat counter on each W fire.
REQ-016 SHALL assert wlast exactly when W beat count == len.
REQ-017 SHALL allow the buffer to enqueue and dequeue in the same cycle; occupancy is unchanged in that case.
REQ-018 SHALL move DATA->RESP in the cycle after both read complete and the wlast fire.
REQ-019 SHALL assert bready in RESP and move RESP->DONE on B fire.
REQ-020 SHALL pulse done for one cycle in DONE, then move DONE->IDLE and clear both beat counters and the AR/AW done flags.
REQ-021 SHALL use 9-bit beat counters so len=255 reaches 256 without wrap.
REQ-022 SHALL set err when rresp != OKAY on an R fire, bresp != OKAY on a B fire, or rlast disagrees with the R beat count.
REQ-023 SHALL hold err until the next command accept, which clears it; an error does not abort the transfer.
REQ-024 SHALL NOT split commands that cross a 4 KB boundary; such commands are outside contract.
REQ-025 SHALL ignore rid and bid.

Reset
REQ-026 SHALL, while resetn is low at a clock edge, enter IDLE and clear counters, flags, buffer pointers and err.
REQ-027 SHALL drive these values after reset: cmd_ready=1; done, err, arvalid, awvalid, rready, wvalid, wlast, bready=0.
REQ-028 SHALL apply reset mid-transfer with the same effect, discarding buffered data; no recovery of the outstanding AXI transaction is performed.

Verification
REQ-029 Single beat: src=0x100, dst=0x200, len=0 -> araddr=0x100, arlen=0, awaddr=0x200; one W with wlast=1 and wdata = read data; done one cycle after B fire.
REQ-030 Backpressure: len=15, slave wready held low 12 cycles -> rready drops after 8 buffered beats; all 16 words written in order; wlast on beat 16 only.
REQ-031 Max burst: len=255, random R/W stalls -> exactly 256 R and 256 W fires; wlast on the 256th W beat only; err=0.
REQ-032 Error: bresp=SLVERR (2'b10) -> err=1 and done still pulses; err stays 1 until the next command accept clears it.
REQ-033 Misaligned address: cmd_src=0x107 -> araddr=0x100.
REQ-034 Reset mid-DATA after 5 beats -> next cycle all valids=0 and cmd_ready=1; a following len=3 command completes correctly.
